// File: rtl/async_fifo.sv
// Single-clock FIFO, 2**ADDR_WIDTH deep. Read data is registered (1-cycle latency).
// Writes while full and reads while empty are silently dropped; full/empty come straight from the pointers.
module async_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] WRAP_BIT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  wr_acc, rd_acc;

  // Flags use only pre-edge pointer state, so a simultaneous request sees the old occupancy.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = ((wr_ptr_q ^ rd_ptr_q) == WRAP_BIT);
  assign dout  = dout_q;

  always_comb begin
    wr_acc   = wr_en & ~full;
    rd_acc   = rd_en & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    dout_d   = dout_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      dout_d   = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      dout_q   <= dout_d;
    end
  end

  // Storage is not reset; stale words are unreachable once the pointers are equal.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= din;
  end

endmodule

// File: tb/tb_async_fifo.sv
// Self-checking bench for async_fifo: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_async_fifo;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          full;
  logic          empty;

  int n_tests;
  int n_fail;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] model_dout;

  async_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst   (rst),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .din   (din),
    .dout  (dout),
    .full  (full),
    .empty (empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle of stimulus; the model applies the FIFO rules using pre-edge occupancy.
  task automatic step(input logic we, input logic re, input logic [DW-1:0] d, input string tag);
    bit was_full;
    bit was_empty;
    wr_en = we;
    rd_en = re;
    din   = d;
    @(posedge clk);
    #1;
    was_full  = (model_q.size() == DEPTH);
    was_empty = (model_q.size() == 0);
    if (re && !was_empty) model_dout = model_q.pop_front();
    if (we && !was_full)  model_q.push_back(d);
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk({tag, "_dout"},  32'(dout),  32'(model_dout));
    chk({tag, "_full"},  32'(full),  32'(model_q.size() == DEPTH));
    chk({tag, "_empty"}, 32'(empty), 32'(model_q.size() == 0));
  endtask

  // Reset pulse placed between clock edges, held across one edge with requests active.
  task automatic mid_reset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    chk({tag, "_rst_empty"}, 32'(empty), 32'd1);
    chk({tag, "_rst_full"},  32'(full),  32'd0);
    chk({tag, "_rst_dout"},  32'(dout),  32'd0);
    wr_en = 1'b1;
    rd_en = 1'b1;
    din   = 8'hC3;
    @(posedge clk);
    #1;
    chk({tag, "_rst_hold_empty"}, 32'(empty), 32'd1);
    wr_en = 1'b0;
    rd_en = 1'b0;
    #1;
    rst = 1'b1;
    model_q.delete();
    model_dout = '0;
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    model_dout = '0;
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;
    #12;
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_full",  32'(full),  32'd0);
    chk("reset_dout",  32'(dout),  32'd0);
    rst = 1'b1;

    // Write path then read order
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 8'(8'hA0 + i), "wr10");
      chk("wr10_not_empty", 32'(empty), 32'd0);
      chk("wr10_not_full",  32'(full),  32'd0);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 8'h00, "rd10");
      chk("rd10_order", 32'(dout), 32'(8'hA0 + i));
    end
    chk("rd10_empty", 32'(empty), 32'd1);

    // Fill, overflow attempt, drain
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i), "fill");
    chk("fill_full", 32'(full), 32'd1);
    step(1'b1, 1'b0, 8'hFF, "overflow");
    chk("overflow_still_full", 32'(full), 32'd1);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00, "drain");
      chk("drain_order", 32'(dout), 32'(i));
    end
    chk("drain_empty", 32'(empty), 32'd1);

    // Underflow holds dout and pointers
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00, "underflow");
    chk("underflow_dout",  32'(dout),  32'h0F);
    chk("underflow_empty", 32'(empty), 32'd1);
    step(1'b1, 1'b0, 8'h55, "post_uf_wr");
    step(1'b0, 1'b1, 8'h00, "post_uf_rd");
    chk("post_uf_dout",  32'(dout),  32'h55);
    chk("post_uf_empty", 32'(empty), 32'd1);

    // Simultaneous access: one entry, then full, then empty
    step(1'b1, 1'b0, 8'h11, "sim1_wr");
    step(1'b1, 1'b1, 8'h22, "sim1_rw");
    chk("sim1_dout",  32'(dout),  32'h11);
    chk("sim1_empty", 32'(empty), 32'd0);
    step(1'b0, 1'b1, 8'h00, "sim1_rd");
    chk("sim1_next",  32'(dout),  32'h22);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h30 + i), "simf_fill");
    step(1'b1, 1'b1, 8'hEE, "simf_rw");
    chk("simf_dout", 32'(dout), 32'h30);
    chk("simf_full", 32'(full), 32'd0);
    for (int i = 1; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00, "simf_drain");
      chk("simf_order", 32'(dout), 32'(8'h30 + i));
    end
    chk("simf_empty", 32'(empty), 32'd1);
    step(1'b1, 1'b1, 8'h77, "sime_rw");
    chk("sime_dout_hold", 32'(dout),  32'h3F);
    chk("sime_not_empty", 32'(empty), 32'd0);
    step(1'b0, 1'b1, 8'h00, "sime_rd");
    chk("sime_dout", 32'(dout), 32'h77);

    // Reset mid-operation with 5 entries stored
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h60 + i), "mr_fill");
    mid_reset("mr");
    step(1'b1, 1'b0, 8'h99, "mr_wr");
    step(1'b0, 1'b1, 8'h00, "mr_rd");
    chk("mr_new_dout", 32'(dout),  32'h99);
    chk("mr_empty",    32'(empty), 32'd1);

    // Randomized traffic, alternating write-heavy and read-heavy phases
    for (int p = 0; p < 8; p++) begin
      for (int i = 0; i < 80; i++) begin
        logic we;
        logic re;
        we = ($urandom_range(99) < ((p % 2 == 0) ? 75 : 25));
        re = ($urandom_range(99) < ((p % 2 == 0) ? 25 : 75));
        step(we, re, 8'($urandom), "rand");
      end
      if (p == 4) mid_reset("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/async_fifo.md
ASYNC_FIFO -- requirements
Module: async_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, address width; depth = 2**ADDR_WIDTH (16 at default).
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous reset, active-low (0 = reset).
REQ-006 SHALL have port wr_en  input  1  write request.
REQ-007 SHALL have port rd_en  input  1  read request.
REQ-008 SHALL have port din  input  DATA_WIDTH  write data.
REQ-009 SHALL have port dout  output  DATA_WIDTH  registered read data.
REQ-010 SHALL have port full  output  1  FIFO holds 2**ADDR_WIDTH entries.
REQ-011 SHALL have port empty  output  1  FIFO holds 0 entries.

Function
REQ-012 SHALL store entries in a 2**ADDR_WIDTH x DATA_WIDTH register array, first-in first-out.
REQ-013 SHALL keep write and read pointers of ADDR_WIDTH+1 bits; low ADDR_WIDTH bits address the array; the MSB is a wrap bit.
REQ-014 SHALL drive empty = 1 exactly when the two pointers are equal (all bits).
REQ-015 SHALL drive full = 1 exactly when the pointers differ only in the MSB.
REQ-016 SHALL derive full and empty combinationally from registered pointers, so both update in the cycle after the causing edge.
REQ-017 SHALL accept a write on a rising clk edge when wr_en = 1 and full = 0: mem[wr_ptr] <= din, wr_ptr increments by 1.
REQ-018 SHALL ignore a write when full = 1: no memory change, no pointer change, no error flag.
REQ-019 SHALL accept a read on a rising clk edge when rd_en = 1 and empty = 0: dout <= mem[rd_ptr], rd_ptr increments by 1.
REQ-020 SHALL give read latency of one cycle: dout shows the read word after the same edge that accepts the read.
REQ-021 SHALL hold dout at its previous value when no read is accepted, including rd_en = 1 while empty = 1.
REQ-022 SHALL wrap pointers modulo 2**(ADDR_WIDTH+1) with no special handling; the array index wraps modulo depth.
REQ-023 SHALL evaluate full and empty from the state before the edge when wr_en and rd_en are both 1 on the same edge.
REQ-024 SHALL perform both the read and the write on a simultaneous request when neither flag blocks; occupancy is unchanged.
REQ-025 SHALL perform only the read on a simultaneous request while full = 1; the write is dropped.
REQ-026 SHALL perform only the write on a simultaneous request while empty = 1; the read is dropped and dout holds.
REQ-027 SHALL not change din, wr_en or rd_en sampling semantics on overflow or underflow attempts; no flag beyond full/empty is raised.

Reset
REQ-028 SHALL, while rst = 0, immediately (asynchronously) clear wr_ptr = 0, rd_ptr = 0 and dout = 0, giving empty = 1 and full = 0.
REQ-029 SHALL leave the memory array contents uncleared on reset; the data is unreachable because pointers are equal.
REQ-030 SHALL discard all stored entries on reset asserted mid-operation, returning empty = 1 on assertion.
REQ-031 SHALL ignore wr_en and rd_en while rst = 0, and resume normal operation on the first rising clk edge after rst returns to 1.

Verification
REQ-032 SHALL be verified for write path: after reset, write 0xA0..0xA9 (10 words) -> empty = 0 after first write, full = 0 throughout.
REQ-033 SHALL be verified for read order: then read 10 times -> dout = 0xA0..0xA9 in order, one per accepting edge, and empty = 1 after the 10th read.
REQ-034 SHALL be verified for full/overflow: write 16 words 0x00..0x0F -> full = 1; a 17th write of 0xFF is ignored; 16 reads return 0x00..0x0F and never 0xFF.
REQ-035 SHALL be verified for underflow: read with rd_en = 1 while empty -> dout holds its last value, pointers unchanged, empty stays 1.
REQ-036 SHALL be verified for simultaneous access: with 1 entry stored, read and write on the same edge -> dout = old entry, occupancy stays 1; when full, same stimulus -> only the read takes effect and full = 0.
REQ-037 SHALL be verified for reset mid-operation: with 5 entries stored, pulse rst = 0 between clock edges -> empty = 1, full = 0 and dout = 0 immediately; the next write/read returns the new data.
